round_robin_mux_arbiter: RTL and testbench

ROUND_ROBIN_MUX_ARBITER -- requirements
Module: round_robin_mux_arbiter

---
 rtl/round_robin_mux_arbiter.sv | 126 ++++++++++++
 tb/tb_round_robin_mux_arbiter.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/round_robin_mux_arbiter.sv
// rtl/round_robin_mux_arbiter.sv - round-robin 8:1 arbiter with data mux; optional grant watchdog under ARB_WATCHDOG_EN
module round_robin_mux_arbiter #(
  parameter int INPUT_LENGTH   = 64,
  parameter int INPUT_WIDTH    = 8,
  parameter int SELECT_WIDTH   = $clog2(INPUT_WIDTH),
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                                clk_i,
  input  logic                                reset_n_i,
  input  logic [INPUT_WIDTH-1:0]              requests_i,
  input  logic [INPUT_WIDTH*INPUT_LENGTH-1:0] inputs_i,
  input  logic                                ready_i,
  output logic [INPUT_WIDTH-1:0]              grants_o,
  output logic [SELECT_WIDTH-1:0]             selects_o,
  output logic [INPUT_LENGTH-1:0]             outputs_o,
  output logic                                valid_o,
  output logic                                timeout_o
);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t                  state, state_next;
  logic [SELECT_WIDTH-1:0] ptr, ptr_next;
  logic [SELECT_WIDTH-1:0] sel_next;
  logic [INPUT_WIDTH-1:0]  grants_next;
  logic [SELECT_WIDTH-1:0] pick, scan_idx;
  logic                    found;
  logic                    timeout_next;

`ifdef ARB_WATCHDOG_EN
  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [WD_W-1:0] wd, wd_next;
`endif

  // First set request at or above ptr, wrapping past the top requester.
  always_comb begin
    found    = 1'b0;
    pick     = ptr;
    scan_idx = ptr;
    for (int i = 0; i < INPUT_WIDTH; i++) begin
      scan_idx = ptr + SELECT_WIDTH'(i);
      if (!found && requests_i[scan_idx]) begin
        found = 1'b1;
        pick  = scan_idx;
      end
    end
  end

  // Next-state logic: arbitrate in IDLE, hold the grant until transfer, abort or watchdog.
  always_comb begin
    state_next   = state;
    ptr_next     = ptr;
    sel_next     = selects_o;
    grants_next  = grants_o;
    timeout_next = 1'b0;
`ifdef ARB_WATCHDOG_EN
    wd_next      = wd;
`endif
    case (state)
      IDLE: begin
        grants_next = '0;
        if (found) begin
          state_next  = GRANT;
          sel_next    = pick;
          grants_next = INPUT_WIDTH'(1) << pick;
`ifdef ARB_WATCHDOG_EN
          wd_next     = '0;
`endif
        end
      end
      GRANT: begin
        // Ready wins over a simultaneous request drop, so both end as a transfer.
        if (ready_i || !requests_i[selects_o]) begin
          state_next  = IDLE;
          ptr_next    = selects_o + SELECT_WIDTH'(1);
          grants_next = '0;
        end
`ifdef ARB_WATCHDOG_EN
        else if (wd == WD_W'(TIMEOUT_CYCLES - 1)) begin
          state_next   = IDLE;
          ptr_next     = selects_o + SELECT_WIDTH'(1);
          grants_next  = '0;
          timeout_next = 1'b1;
        end else begin
          wd_next = wd + WD_W'(1);
        end
`endif
      end
      default: state_next = IDLE;
    endcase
  end

  // State, pointer and registered grant outputs.
  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      state     <= IDLE;
      ptr       <= '0;
      selects_o <= '0;
      grants_o  <= '0;
    end else begin
      state     <= state_next;
      ptr       <= ptr_next;
      selects_o <= sel_next;
      grants_o  <= grants_next;
    end
  end

`ifdef ARB_WATCHDOG_EN
  // Watchdog counter and one-cycle revocation pulse.
  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      wd        <= '0;
      timeout_o <= 1'b0;
    end else begin
      wd        <= wd_next;
      timeout_o <= timeout_next;
    end
  end
`else
  assign timeout_o = timeout_next;
`endif

  assign valid_o   = (state == GRANT);
  assign outputs_o = valid_o ? inputs_i[selects_o*INPUT_LENGTH +: INPUT_LENGTH] : '0;

endmodule

// File: tb/tb_round_robin_mux_arbiter.sv
// tb/tb_round_robin_mux_arbiter.sv - directed self-checking bench for round_robin_mux_arbiter
module tb_round_robin_mux_arbiter;

  logic         clk = 1'b0;
  logic         reset_n;
  logic [7:0]   requests;
  logic [511:0] inputs;
  logic         ready;
  logic [7:0]   grants;
  logic [2:0]   selects;
  logic [63:0]  outputs;
  logic         valid;
  logic         timeout;

  int total = 0;
  int bad   = 0;

  round_robin_mux_arbiter dut (
    .clk_i     (clk),
    .reset_n_i (reset_n),
    .requests_i(requests),
    .inputs_i  (inputs),
    .ready_i   (ready),
    .grants_o  (grants),
    .selects_o (selects),
    .outputs_o (outputs),
    .valid_o   (valid),
    .timeout_o (timeout)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] word(input int k);
    return 64'hDEAD_BEEF_0000_0000 + 64'(k) * 64'h0001_0101_0011_1111;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_grant(input string tag, input int k);
    chk({tag, "_grants"}, 64'(grants), 64'(8'(1) << k));
    chk({tag, "_selects"}, 64'(selects), 64'(k));
    chk({tag, "_valid"}, 64'(valid), 64'd1);
    chk({tag, "_outputs"}, outputs, word(k));
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_grants"}, 64'(grants), 64'd0);
    chk({tag, "_valid"}, 64'(valid), 64'd0);
    chk({tag, "_outputs"}, outputs, 64'd0);
  endtask

  initial begin
    for (int k = 0; k < 8; k++) inputs[k*64 +: 64] = word(k);
    reset_n  = 1'b0;
    requests = 8'h00;
    ready    = 1'b0;
    step(); step(); step();
    chk_idle("reset");
    chk("reset_selects", 64'(selects), 64'd0);
    chk("reset_timeout", 64'(timeout), 64'd0);

    reset_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      chk_idle("no_req");
    end

    // All requesting, always ready: 0..7 then 0, alternate cycles.
    requests = 8'hFF;
    ready    = 1'b1;
    for (int k = 0; k < 9; k++) begin
      step();
      chk_grant("rr", k % 8);
      if (k == 8) requests = 8'h00;
      step();
      chk_idle("rr_gap");
    end

    // ptr = 1 with requests 0 and 7: wrap-around.
    requests = 8'h81;
    step();
    chk_grant("wrap7", 7);
    step();
    chk_idle("wrap_gap");
    step();
    chk_grant("wrap0", 0);
    requests = 8'h00;
    step();
    chk_idle("wrap_end");

    // Grant 3, others change mid-grant, then request 3 drops without ready.
    requests = 8'h08;
    ready    = 1'b0;
    step();
    chk_grant("g3", 3);
    requests = 8'h0F;
    step();
    chk_grant("g3_hold", 3);
    requests = 8'h07;
    step();
    chk_idle("abort");
    chk("abort_timeout", 64'(timeout), 64'd0);
    requests = 8'h21;
    step();
    chk_grant("after_abort", 5);

`ifdef ARB_WATCHDOG_EN
    for (int i = 0; i < 15; i++) begin
      step();
      chk_grant("wd_hold", 5);
      chk("wd_hold_timeout", 64'(timeout), 64'd0);
    end
    step();
    chk_idle("wd_revoke");
    chk("wd_pulse", 64'(timeout), 64'd1);
    requests = 8'h00;
    step();
    chk("wd_pulse_end", 64'(timeout), 64'd0);
    chk_idle("wd_idle");
`else
    for (int i = 0; i < 20; i++) begin
      step();
      chk_grant("hold", 5);
      chk("hold_timeout", 64'(timeout), 64'd0);
    end
    ready    = 1'b1;
    requests = 8'h00;
    step();
    chk_idle("hold_done");
`endif

    // ptr should now be 6.
    ready    = 1'b1;
    requests = 8'h41;
    step();
    chk_grant("ptr6", 6);
    step();
    chk_idle("ptr6_gap");
    step();
    chk_grant("ptr7_wrap", 0);

    // Reset during an active grant with ready high.
    reset_n = 1'b0;
    step();
    chk_idle("mid_reset");
    chk("mid_reset_selects", 64'(selects), 64'd0);
    reset_n  = 1'b1;
    ready    = 1'b0;
    step();
    chk_grant("post_reset_ptr0", 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
